// File: rtl/io_pkg.sv
// Shared types and limits for the I/O register bank: cycle FSM states and
// parameter ranges.
package io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } cyc_state_t;

    localparam int MAX_NREGS       = 16;
    localparam int MAX_WAIT_STATES = 7;
    localparam int WCNT_W          = 3;

    // Counter preload for the WAIT state; the count runs down to zero.
    function automatic logic [WCNT_W-1:0] wait_load(input int ws);
        int m;
        m = (ws > MAX_WAIT_STATES) ? MAX_WAIT_STATES : ws;
        return (m > 0) ? WCNT_W'(m - 1) : '0;
    endfunction

endpackage

// File: rtl/io_reg_bank_if.sv
// I/O bus seen by the register bank: request, address/data and termination.
interface io_reg_bank_if;

    logic [15:0] adr_i;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        we_i;
    logic        stb_i;
    logic        mio_i;
    logic        byte_i;
    logic        ack_o;

    modport master (
        output adr_i, dat_i, we_i, stb_i, mio_i, byte_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  adr_i, dat_i, we_i, stb_i, mio_i, byte_i,
        output dat_o, ack_o
    );

endinterface

// File: rtl/io_cycle_ctl.sv
// Bus cycle sequencer: IDLE -> (WAIT) -> ACK with a programmable number of
// wait states and abort on request withdrawal.
module io_cycle_ctl
    import io_pkg::*;
#(
    parameter int WAIT_STATES  = 0,
    parameter bit ACK_UNMAPPED = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_i,
    input  logic hit_i,
    output logic commit_o,
    output logic ack_o
);

    localparam logic [WCNT_W-1:0] WS_LOAD = wait_load(WAIT_STATES);

    cyc_state_t        r_state;
    cyc_state_t        w_next;
    logic [WCNT_W-1:0] r_cnt;
    logic [WCNT_W-1:0] w_cnt_nxt;
    logic              w_accept;

    assign w_accept = req_i && (hit_i || ACK_UNMAPPED);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        ack_o     = 1'b0;
        commit_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES > 0) begin
                        w_next    = ST_WAIT;
                        w_cnt_nxt = WS_LOAD;
                    end else begin
                        w_next = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (!req_i) begin
                    w_next    = ST_IDLE;
                    w_cnt_nxt = '0;
                end else if (r_cnt == '0) begin
                    w_next = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_ACK: begin
                ack_o = 1'b1;
                // A write only lands if the master still holds the request.
                commit_o = req_i;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next    = ST_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/io_reg_bank.sv
// Bank of 16-bit I/O-mapped registers with byte lanes, read-only status
// slots and per-register write strobes.
module io_reg_bank
    import io_pkg::*;
#(
    parameter logic [15:0]      BASE         = 16'h00B6,
    parameter int               NREGS        = 4,
    parameter int               WAIT_STATES  = 0,
    parameter logic [NREGS-1:0] RO_MASK      = '0,
    parameter bit               ACK_UNMAPPED = 1'b1,
    parameter logic [15:0]      INIT         = 16'h0000
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    io_reg_bank_if.slave          bus,
    output logic [NREGS*16-1:0]   regs_o,
    input  logic [NREGS*16-1:0]   status_i,
    output logic [NREGS-1:0]      wr_stb_o
);

    logic [15:0]          w_off;
    logic [14:0]          w_idx;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_commit;
    logic                 w_ack;
    logic [NREGS-1:0]     w_we;
    logic [NREGS-1:0]     r_wr_stb;
    logic [15:0]          w_rdval;
    logic [15:0]          w_rdsel;
    wire  [NREGS*16-1:0]  w_regs;

    // Word accesses at odd ports fall on the same register: only adr[15:1] decodes.
    assign w_off = bus.adr_i - BASE;
    assign w_idx = w_off[15:1];
    assign w_req = bus.stb_i && bus.mio_i;
    assign w_hit = w_req && (bus.adr_i >= BASE) && (w_idx < 15'(NREGS));

    io_cycle_ctl #(
        .WAIT_STATES  (WAIT_STATES),
        .ACK_UNMAPPED (ACK_UNMAPPED)
    ) u_ctl (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .req_i    (w_req),
        .hit_i    (w_hit),
        .commit_o (w_commit),
        .ack_o    (w_ack)
    );

    always_comb begin
        w_we = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (w_commit && bus.we_i && w_hit && (w_idx == 15'(k)) && !RO_MASK[k])
                w_we[k] = 1'b1;
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_reg
        if (RO_MASK[k]) begin : g_ro
            assign w_regs[k*16 +: 16] = status_i[k*16 +: 16];
        end else begin : g_rw
            logic [15:0] r_val;
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_val <= INIT;
                end else if (w_we[k]) begin
                    if (!bus.byte_i)
                        r_val <= bus.dat_i;
                    else if (bus.adr_i[0])
                        r_val[15:8] <= bus.dat_i[7:0];
                    else
                        r_val[7:0] <= bus.dat_i[7:0];
                end
            end
            assign w_regs[k*16 +: 16] = r_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_wr_stb <= '0;
        else
            r_wr_stb <= w_we;
    end

    always_comb begin
        w_rdval = 16'h0000;
        for (int k = 0; k < NREGS; k++) begin
            if (w_idx == 15'(k))
                w_rdval = w_regs[k*16 +: 16];
        end
    end

    always_comb begin
        if (!bus.byte_i)
            w_rdsel = w_rdval;
        else if (bus.adr_i[0])
            w_rdsel = {8'h00, w_rdval[15:8]};
        else
            w_rdsel = {8'h00, w_rdval[7:0]};
    end

    assign bus.dat_o = (w_ack && w_hit) ? w_rdsel : 16'h0000;
    assign bus.ack_o = w_ack;
    assign regs_o    = w_regs;
    assign wr_stb_o  = r_wr_stb;

    // Status lanes of writable registers and the byte-select offset bit are not needed here.
    wire w_unused = &{1'b0, status_i, w_off[0]};

endmodule
